// File: rtl/probatina_chunk_scheduler.sv
// probatina_chunk_scheduler
//
// Sits between the host-facing ap_* handshake and a single vadd engine.
// On a host start it splits ctrl_total_bytes into chunks of at most
// ctrl_chunk_bytes (rounded down to whole AXI beats). For each chunk it issues
// one engine start pulse with the chunk's address and size, then waits for the
// engine's done pulse. After the last chunk it pulses ap_done/ap_ready.
//
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   ap_start                 host start (level; only a rising edge is used)
//   ap_idle/ap_done/ap_ready host status (ap_ready mirrors ap_done)
//   ctrl_base_addr           start address, sampled at start
//   ctrl_total_bytes         bytes to move, sampled at start
//   ctrl_chunk_bytes         max chunk size (0 selects C_DEFAULT_CHUNK_BYTES)
//   eng_start                one-cycle engine start pulse
//   eng_addr_offset          chunk address, held until the next issue
//   eng_xfer_size_in_bytes   chunk size, held until the next issue
//   eng_done                 engine done pulse (honoured only while waiting)
//   stat_chunks              chunks completed this run, saturating
module probatina_chunk_scheduler #(
    parameter int C_ADDR_WIDTH          = 64,
    parameter int C_XFER_SIZE_WIDTH     = 32,
    parameter int C_DATA_WIDTH          = 512,
    parameter int C_DEFAULT_CHUNK_BYTES = 16384
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_base_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_total_bytes,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_chunk_bytes,
    output logic                         eng_start,
    output logic [C_ADDR_WIDTH-1:0]      eng_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] eng_xfer_size_in_bytes,
    input  logic                         eng_done,
    output logic [15:0]                  stat_chunks
);

    localparam logic [C_XFER_SIZE_WIDTH-1:0] BEAT      = C_XFER_SIZE_WIDTH'(C_DATA_WIDTH / 8);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] DEF_CHUNK = C_XFER_SIZE_WIDTH'(C_DEFAULT_CHUNK_BYTES);

    // Effective chunk: default when zero, then whole beats only, never below one beat.
    function automatic logic [C_XFER_SIZE_WIDTH-1:0] eff_chunk(
        input logic [C_XFER_SIZE_WIDTH-1:0] req
    );
        logic [C_XFER_SIZE_WIDTH-1:0] c;
        logic [C_XFER_SIZE_WIDTH-1:0] r;
        c = (req == '0) ? DEF_CHUNK : req;
        r = c - (c % BEAT);
        return (r == '0) ? BEAT : r;
    endfunction

    function automatic logic [C_XFER_SIZE_WIDTH-1:0] min_size(
        input logic [C_XFER_SIZE_WIDTH-1:0] a,
        input logic [C_XFER_SIZE_WIDTH-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                         state;
    logic                           ap_start_r;
    logic [C_ADDR_WIDTH-1:0]        base_q;
    logic [C_XFER_SIZE_WIDTH-1:0]   total_q;
    logic [C_XFER_SIZE_WIDTH-1:0]   chunk_req_q;
    logic [C_XFER_SIZE_WIDTH-1:0]   chunk_q;
    logic [C_XFER_SIZE_WIDTH-1:0]   remaining;
    logic [C_ADDR_WIDTH-1:0]        cur_addr;

    logic                           start_edge;
    logic [C_XFER_SIZE_WIDTH-1:0]   chunk_eff;
    logic [C_XFER_SIZE_WIDTH-1:0]   rem_next;
    logic [C_ADDR_WIDTH-1:0]        addr_next;

    // The size register always holds the chunk in flight, so the post-done
    // remainder and address are derived from it directly.
    assign start_edge = ap_start & ~ap_start_r;
    assign chunk_eff  = eff_chunk(chunk_req_q);
    assign rem_next   = remaining - eng_xfer_size_in_bytes;
    assign addr_next  = cur_addr + C_ADDR_WIDTH'(eng_xfer_size_in_bytes);
    assign ap_ready   = ap_done;

    // Transfer bookkeeping: only meaningful inside a run, so no reset.
    always_ff @(posedge ap_clk) begin
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    base_q      <= ctrl_base_addr;
                    total_q     <= ctrl_total_bytes;
                    chunk_req_q <= ctrl_chunk_bytes;
                end
            end
            S_LOAD: begin
                chunk_q   <= chunk_eff;
                remaining <= total_q;
                cur_addr  <= base_q;
            end
            S_WAIT: begin
                if (eng_done) begin
                    remaining <= rem_next;
                    cur_addr  <= addr_next;
                end
            end
            default: ;
        endcase
    end

    // Sequencer and registered outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state                  <= S_IDLE;
            ap_start_r             <= 1'b0;
            ap_idle                <= 1'b1;
            ap_done                <= 1'b0;
            eng_start              <= 1'b0;
            eng_addr_offset        <= '0;
            eng_xfer_size_in_bytes <= '0;
            stat_chunks            <= '0;
        end else begin
            ap_start_r <= ap_start;
            eng_start  <= 1'b0;
            ap_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state       <= S_LOAD;
                        ap_idle     <= 1'b0;
                        stat_chunks <= '0;
                    end
                end
                S_LOAD: begin
                    if (total_q == '0) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state                  <= S_ISSUE;
                        eng_start              <= 1'b1;
                        eng_addr_offset        <= base_q;
                        eng_xfer_size_in_bytes <= min_size(total_q, chunk_eff);
                    end
                end
                S_ISSUE: begin
                    // A done pulse coincident with the start is not for this chunk.
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        if (stat_chunks != 16'hFFFF) begin
                            stat_chunks <= stat_chunks + 16'd1;
                        end
                        if (rem_next == '0) begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state                  <= S_ISSUE;
                            eng_start              <= 1'b1;
                            eng_addr_offset        <= addr_next;
                            eng_xfer_size_in_bytes <= min_size(rem_next, chunk_q);
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_probatina_chunk_scheduler.sv
// Testbench for probatina_chunk_scheduler: directed cases from the chunking
// rules plus randomized transfers, checked against a queue-based model of the
// expected (address, size) sequence.
module tb_probatina_chunk_scheduler;

    localparam int AW  = 64;
    localparam int XW  = 32;
    localparam int DW  = 512;
    localparam int DEF = 16384;
    localparam int B   = DW / 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_idle;
    logic          ap_done;
    logic          ap_ready;
    logic [AW-1:0] ctrl_base_addr;
    logic [XW-1:0] ctrl_total_bytes;
    logic [XW-1:0] ctrl_chunk_bytes;
    logic          eng_start;
    logic [AW-1:0] eng_addr_offset;
    logic [XW-1:0] eng_xfer_size_in_bytes;
    logic          eng_done;
    logic [15:0]   stat_chunks;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_addr[$];
    logic [63:0] exp_size[$];

    always #5 ap_clk = ~ap_clk;

    probatina_chunk_scheduler #(
        .C_ADDR_WIDTH          (AW),
        .C_XFER_SIZE_WIDTH     (XW),
        .C_DATA_WIDTH          (DW),
        .C_DEFAULT_CHUNK_BYTES (DEF)
    ) dut (
        .ap_clk                 (ap_clk),
        .ap_rst_n               (ap_rst_n),
        .ap_start               (ap_start),
        .ap_idle                (ap_idle),
        .ap_done                (ap_done),
        .ap_ready               (ap_ready),
        .ctrl_base_addr         (ctrl_base_addr),
        .ctrl_total_bytes       (ctrl_total_bytes),
        .ctrl_chunk_bytes       (ctrl_chunk_bytes),
        .eng_start              (eng_start),
        .eng_addr_offset        (eng_addr_offset),
        .eng_xfer_size_in_bytes (eng_xfer_size_in_bytes),
        .eng_done               (eng_done),
        .stat_chunks            (stat_chunks)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge ap_clk);
    endtask

    // Reference: list of chunks a transfer must be split into.
    task automatic model(input logic [63:0] base, input logic [31:0] total, input logic [31:0] chunk);
        longint unsigned c;
        longint unsigned rem;
        longint unsigned sz;
        logic [63:0]     a;
        exp_addr.delete();
        exp_size.delete();
        c = (chunk == 0) ? DEF : chunk;
        c = (c / B) * B;
        if (c == 0) c = B;
        rem = total;
        a   = base;
        while (rem > 0) begin
            sz = (rem < c) ? rem : c;
            exp_addr.push_back(a);
            exp_size.push_back(sz);
            rem -= sz;
            a   += sz;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"},  ap_idle, 1);
        chk({tag, "_done"},  ap_done, 0);
        chk({tag, "_ready"}, ap_ready, 0);
        chk({tag, "_start"}, eng_start, 0);
        chk({tag, "_addr"},  eng_addr_offset, 0);
        chk({tag, "_size"},  eng_xfer_size_in_bytes, 0);
        chk({tag, "_stat"},  stat_chunks, 0);
    endtask

    // One full run. hold keeps ap_start high throughout; poke injects a done
    // during ISSUE and a second start edge during WAIT.
    task automatic run_xfer(input logic [63:0] base, input logic [31:0] total,
                            input logic [31:0] chunk, input bit hold, input bit poke);
        int n;
        int d;
        model(base, total, chunk);
        n = exp_size.size();
        ctrl_base_addr   = base;
        ctrl_total_bytes = total;
        ctrl_chunk_bytes = chunk;
        ap_start         = 1'b1;
        tick;
        chk("load_idle", ap_idle, 0);
        chk("load_start", eng_start, 0);
        if (!hold) ap_start = 1'b0;
        tick;
        for (int i = 0; i < n; i++) begin
            chk("issue_start", eng_start, 1);
            chk("issue_addr", eng_addr_offset, exp_addr[i]);
            chk("issue_size", eng_xfer_size_in_bytes, exp_size[i]);
            chk("issue_stat", stat_chunks, 64'(i));
            chk("issue_done", ap_done, 0);
            eng_done = poke && ($urandom_range(0, 1) == 1);
            tick;
            eng_done = 1'b0;
            chk("wait_start", eng_start, 0);
            chk("wait_stat", stat_chunks, 64'(i));
            d = $urandom_range(0, 4);
            for (int k = 0; k < d; k++) begin
                if (!hold) ap_start = poke && (k == 0);
                tick;
                chk("wait_hold", eng_start, 0);
                chk("wait_nodone", ap_done, 0);
            end
            if (!hold) ap_start = 1'b0;
            eng_done = 1'b1;
            tick;
            eng_done = 1'b0;
        end
        chk("end_done", ap_done, 1);
        chk("end_ready", ap_ready, 1);
        chk("end_stat", stat_chunks, 64'(n));
        chk("end_busy", ap_idle, 0);
        chk("end_nostart", eng_start, 0);
        tick;
        chk("post_idle", ap_idle, 1);
        chk("post_done", ap_done, 0);
        chk("post_stat", stat_chunks, 64'(n));
        if (hold) begin
            for (int k = 0; k < 4; k++) begin
                tick;
                chk("hold_idle", ap_idle, 1);
                chk("hold_nostart", eng_start, 0);
            end
            ap_start = 1'b0;
        end
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] saved_addr;
        logic [15:0] saved_stat;
        ap_rst_n         = 1'b0;
        ap_start         = 1'b0;
        eng_done         = 1'b0;
        ctrl_base_addr   = '0;
        ctrl_total_bytes = '0;
        ctrl_chunk_bytes = '0;
        tick;
        tick;
        check_reset_outputs("rst");
        ap_rst_n = 1'b1;
        tick;

        run_xfer(64'h1000, 16384, 0, 0, 0);
        run_xfer(64'h0, 10000, 4096, 0, 0);
        run_xfer(64'h0, 200, 100, 0, 0);
        run_xfer(64'h40, 64, 10, 0, 0);
        run_xfer(64'h2000, 0, 4096, 0, 0);
        run_xfer(64'h0, 8192, 4096, 1, 0);
        run_xfer(64'h0, 12288, 4096, 0, 1);
        run_xfer(64'hFFFF_FFFF_FFFF_F000, 8192, 4096, 0, 0);

        // Done pulses while idle must change nothing.
        saved_addr = eng_addr_offset;
        saved_stat = stat_chunks;
        eng_done = 1'b1;
        tick;
        tick;
        eng_done = 1'b0;
        tick;
        chk("idle_done_stat", stat_chunks, saved_stat);
        chk("idle_done_addr", eng_addr_offset, saved_addr);
        chk("idle_done_idle", ap_idle, 1);
        chk("idle_done_start", eng_start, 0);

        // Reset during WAIT abandons the run immediately.
        ctrl_base_addr   = 64'h5000;
        ctrl_total_bytes = 8192;
        ctrl_chunk_bytes = 4096;
        ap_start = 1'b1;
        tick;
        ap_start = 1'b0;
        tick;
        chk("rstw_issue", eng_start, 1);
        tick;
        tick;
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("rstw");
        tick;
        ap_rst_n = 1'b1;
        tick;
        check_reset_outputs("rstw_rel");
        run_xfer(64'h3000, 4160, 4096, 0, 0);

        for (int r = 0; r < 25; r++) begin
            logic [63:0] base;
            logic [31:0] total;
            logic [31:0] chunk;
            base  = {$urandom, $urandom};
            total = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3000);
            chunk = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 1200);
            run_xfer(base, total, chunk, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/probatina_chunk_scheduler.md
# probatina_chunk_scheduler

Control sequencer between the kernel's host-facing `ap_*` handshake and one vadd datapath engine. On each host start it splits a transfer of `ctrl_total_bytes` into chunks of at most `ctrl_chunk_bytes`. It issues one engine start pulse per chunk with the matching address offset and size, waits for the engine's done pulse, and advances. After the last chunk it signals `ap_done`/`ap_ready` to the host. It replaces the fixed single-transfer start/done glue at the kernel top level.

## Interface
Parameters:
- `C_ADDR_WIDTH`, 64 — address width of the offset outputs.
- `C_XFER_SIZE_WIDTH`, 32 — width of byte counts.
- `C_DATA_WIDTH`, 512 — engine AXI data width. Beat size is B = C_DATA_WIDTH/8 bytes.
- `C_DEFAULT_CHUNK_BYTES`, 16384 — chunk size used when `ctrl_chunk_bytes` is 0.

Ports:
- `ap_clk` in 1 — single clock; every flop is on its rising edge.
- `ap_rst_n` in 1 — reset, asynchronous, active-low.
- `ap_start` in 1 — host start, level. Only a rising edge is acted on.
- `ap_idle` out 1 — block idle.
- `ap_done` out 1 — one-cycle pulse when the whole transfer is complete.
- `ap_ready` out 1 — equal to `ap_done` (non-pipelined).
- `ctrl_base_addr` in C_ADDR_WIDTH — start address. Sampled at start.
- `ctrl_total_bytes` in C_XFER_SIZE_WIDTH — total bytes to process. Sampled at start.
- `ctrl_chunk_bytes` in C_XFER_SIZE_WIDTH — maximum chunk size. Sampled at start.
- `eng_start` out 1 — one-cycle start pulse to the engine.
- `eng_addr_offset` out C_ADDR_WIDTH — chunk address. Valid with `eng_start`; held until the next issue.
- `eng_xfer_size_in_bytes` out C_XFER_SIZE_WIDTH — chunk size. Valid with `eng_start`; held until the next issue.
- `eng_done` in 1 — engine done pulse.
- `stat_chunks` out 16 — number of chunks completed in the current or last run. Saturates at 0xFFFF.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- Start detection: `ap_start_r` registers `ap_start`. A start is `ap_start & ~ap_start_r`, and it is acted on only in IDLE.
  - Starts seen in any other state are dropped, not queued.
  - Holding `ap_start` high after a run does not restart the block; a new rising edge is required.
- IDLE → LOAD on a start.
  - Capture base, total and chunk size.
  - Clear `stat_chunks`.
- LOAD computes the effective chunk size and checks for an empty transfer.
  - chunk = (`ctrl_chunk_bytes` == 0) ? C_DEFAULT_CHUNK_BYTES : `ctrl_chunk_bytes`.
  - The chunk is then rounded down to a multiple of B. If the result is 0, the chunk becomes B.
  - remaining = total; cur_addr = base.
  - LOAD → DONE if total == 0. No engine start is issued in that case.
  - Otherwise LOAD → ISSUE.
- ISSUE, lasting one cycle:
  - `eng_start`=1.
  - `eng_xfer_size_in_bytes` = min(remaining, chunk).
  - `eng_addr_offset` = cur_addr.
  - ISSUE → WAIT.
- WAIT on `eng_done`:
  - remaining -= size; cur_addr += size (modulo 2^C_ADDR_WIDTH, wraps silently).
  - `stat_chunks` increments, saturating.
  - Then → DONE if remaining == 0, else → ISSUE.
- A total that is not a multiple of B produces a short last chunk carrying the exact remainder.
- `eng_done` outside WAIT is ignored. `eng_done` coincident with `eng_start` is also ignored.
- DONE, lasting one cycle: `ap_done`=`ap_ready`=1. DONE → IDLE.
- `ap_idle` = 1 exactly when the state is IDLE. All outputs are registered.

## Timing
- Reset (`ap_rst_n`=0) takes effect immediately and asynchronously:
  - State IDLE; `ap_idle`=1.
  - `ap_done`=`ap_ready`=`eng_start`=0.
  - `eng_addr_offset`=0, `eng_xfer_size_in_bytes`=0, `stat_chunks`=0, `ap_start_r`=0.
- Reset mid-run abandons the run with no `ap_done`. The engine is not reset by this block.
- A start rising edge seen at clock edge N gives:
  - LOAD from N+1 (`ap_idle`=0).
  - ISSUE from N+2 (`eng_start`=1).
  - WAIT from N+3.
- `eng_done` sampled at edge M leads to the next `eng_start` at M+1, or to `ap_done` at M+1 on the last chunk. Per-chunk overhead is therefore 2 cycles.
- `ap_idle` returns to 1 one cycle after the `ap_done` pulse.
- With total == 0, `ap_done` is high in cycle N+2.

## Test plan
- Default chunk: total=16384, chunk=0, base=0x1000. Required response: one `eng_start` with addr 0x1000, size 16384. `eng_done` → `ap_done` pulse of 1 cycle one cycle later, `stat_chunks`=1, `ap_idle` high on the following cycle.
- Multi-chunk: total=10000, chunk=4096, base=0. Required response: starts of (0x0, 4096), (0x1000, 4096), (0x2000, 1808). Each start comes 1 cycle after the previous `eng_done`. `stat_chunks`=3, then `ap_done`.
- Rounding: chunk=100, total=200 → sizes 64, 64, 64, 8. chunk=10, total=64 → one chunk of 64.
- Empty: total=0 → no `eng_start`; `ap_done`=1 at N+2; `stat_chunks`=0.
- Robustness:
  - `ap_start` held high across completion → no second run.
  - A second rising edge during WAIT → ignored.
  - `eng_done` pulses in IDLE or ISSUE → ignored; counts and addresses unchanged.
- Reset and wrap:
  - `ap_rst_n` low during WAIT → all outputs at reset values immediately. After release, a new start runs normally.
  - base=0xFFFF_FFFF_FFFF_F000, total=8192, chunk=4096 → second start addr 0x0.
